// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner
//
// Push-button front end for the game controller. Each channel has a 2-flop
// synchroniser, a stable-time debouncer and a rising-edge detector. A shared
// lockout arbiter turns the edges into move pulses. It emits at most one
// single-cycle, one-hot pulse per lockout window. Bit 0 has the highest
// priority. Requests that lose arbitration, or that arrive while the lockout
// is running, are dropped rather than queued.
//
// Optional feature: define BUTTON_PULSE_AUTOREPEAT_EN to add per-channel hold
// counters. A held button then raises repeat requests REPEAT_DELAY cycles
// after its rising edge, and every REPEAT_PERIOD cycles after that. Without
// the macro, a held button yields exactly one pulse and the REPEAT_*
// parameters have no effect.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   btn_in     raw asynchronous button levels, active-high   [NUM_CH]
//   level_out  debounced button levels                       [NUM_CH]
//   pulse_out  one-hot, single-cycle move pulse (registered) [NUM_CH]
//   busy       high while the lockout counter is non-zero

module button_pulse_conditioner #(
   parameter int NUM_CH          = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOCKOUT_CYCLES  = 15,
   parameter int REPEAT_DELAY    = 1000,
   parameter int REPEAT_PERIOD   = 250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] pulse_out,
   output logic              busy
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   // A zero lockout still needs a one-bit counter so that the vector is legal.
   localparam int LK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

   localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES);

   logic [NUM_CH-1:0] sync_q1;
   logic [NUM_CH-1:0] sync_q2;
   logic [DB_W-1:0]   db_cnt [NUM_CH];
   logic [NUM_CH-1:0] level_d;
   logic [NUM_CH-1:0] req_edge;
   logic [NUM_CH-1:0] rep_req;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [LK_W-1:0]   lock_cnt;

   // Synchroniser
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce
   // The counter counts consecutive synced cycles that disagree with the
   // current level. The level toggles on the cycle the count would reach
   // DEBOUNCE_CYCLES, which is why the compare is against DEBOUNCE_CYCLES-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            db_cnt[i] <= '0;
         end
         level_out <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync_q2[i] == level_out[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_TC) begin
               db_cnt[i]    <= '0;
               level_out[i] <= ~level_out[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Edge detect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_d <= '0;
      end else begin
         level_d <= level_out;
      end
   end

   assign req_edge = level_out & ~level_d;

`ifdef BUTTON_PULSE_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W  = $clog2(REP_MAX + 1);

   localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD - 1);

   logic [HOLD_W-1:0] hold_cnt [NUM_CH];

   // The hold timer is a down-counter that is loaded on the cycle after the
   // rising edge. It reaches zero exactly REPEAT_DELAY cycles after the edge,
   // and then every REPEAT_PERIOD cycles. level_d gates out the idle zero
   // that the counter holds during the edge cycle itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!level_out[i]) begin
               hold_cnt[i] <= '0;
            end else if (req_edge[i]) begin
               hold_cnt[i] <= HOLD_DELAY;
            end else if (hold_cnt[i] == '0) begin
               hold_cnt[i] <= HOLD_PERIOD;
            end else begin
               hold_cnt[i] <= hold_cnt[i] - HOLD_W'(1);
            end
         end
      end
   end

   always_comb begin
      rep_req = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rep_req[i] = level_out[i] & level_d[i] & (hold_cnt[i] == '0);
      end
   end
`else
   // The repeat timing has no effect in this build.
   logic [31:0] unused_repeat_cfg;
   assign unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
   assign rep_req           = '0;
`endif

   assign req = req_edge | rep_req;

   // Lowest set bit wins. req & -req isolates it in two's complement.
   always_comb begin
      grant = '0;
      if (lock_cnt == '0) begin
         grant = req & (~req + NUM_CH'(1));
      end
   end

   // Lockout timer and registered pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_cnt  <= '0;
         pulse_out <= '0;
      end else begin
         pulse_out <= grant;
         if (grant != '0) begin
            lock_cnt <= LK_LOAD;
         end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LK_W'(1);
         end
      end
   end

   assign busy = (lock_cnt != '0);

endmodule

// File: tb/tb_button_pulse_conditioner.sv
module tb_button_pulse_conditioner;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] btn_in = 3'b000;
   logic [2:0] level_out;
   logic [2:0] pulse_out;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] prev_pulse = 3'b000;
   logic [2:0] exp_pulse;
   logic       exp_busy;

   button_pulse_conditioner #(
      .NUM_CH(3),
      .DEBOUNCE_CYCLES(4),
      .LOCKOUT_CYCLES(8),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .level_out(level_out),
      .pulse_out(pulse_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, expd);
      end
   endtask

   // Advance one cycle and sample 1 time unit after the rising edge.
   // The pulse invariants are checked on every cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      check("onehot0", {2'b00, $onehot0(pulse_out)}, 3'b001);
      check("no_back_to_back", {2'b00, (prev_pulse != 3'b000) && (pulse_out != 3'b000)}, 3'b000);
      prev_pulse = pulse_out;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with all buttons held
      btn_in = 3'b111;
      tick(); tick(); tick();
      check("reset_level", level_out, 3'b000);
      check("reset_pulse", pulse_out, 3'b000);
      check("reset_busy", {2'b00, busy}, 3'b000);
      rst = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 20) btn_in = 3'b000;
         check("hold_level", level_out, (k >= 6 && k < 26) ? 3'b111 : 3'b000);
         check("hold_pulse", pulse_out, (k == 7) ? 3'b001 : 3'b000);
         check("hold_busy", {2'b00, (busy)}, {2'b00, (k >= 7 && k <= 14)});
      end

      // Single clean press on bit 1
      btn_in = 3'b010;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 14) btn_in = 3'b000;
         check("single_level", level_out, (k >= 6 && k < 20) ? 3'b010 : 3'b000);
         check("single_pulse", pulse_out, (k == 7) ? 3'b010 : 3'b000);
         check("single_busy", {2'b00, busy}, {2'b00, (k >= 7 && k <= 14)});
      end

      // Bounce on bit 2: 1,0,1,0, then stays 1
      btn_in = 3'b100; tick(); check("bounce_level", level_out, 3'b000);
      btn_in = 3'b000; tick(); check("bounce_level", level_out, 3'b000);
      btn_in = 3'b100; tick(); check("bounce_level", level_out, 3'b000);
      btn_in = 3'b000; tick(); check("bounce_level", level_out, 3'b000);
      btn_in = 3'b100;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 14) btn_in = 3'b000;
         check("bounce_level", level_out, (k >= 6 && k < 20) ? 3'b100 : 3'b000);
         check("bounce_pulse", pulse_out, (k == 7) ? 3'b100 : 3'b000);
      end

      // Bits 0 and 2 pressed together: bit 0 wins, bit 2 is dropped
      btn_in = 3'b101;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 14) btn_in = 3'b000;
         check("simul_level", level_out, (k >= 6 && k < 20) ? 3'b101 : 3'b000);
         check("simul_pulse", pulse_out, (k == 7) ? 3'b001 : 3'b000);
         check("simul_busy", {2'b00, busy}, {2'b00, (k >= 7 && k <= 14)});
      end

      // Bit 1 pulse, bit 0 edge while busy is dropped, bit 0 again after lockout
      btn_in = 3'b010;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (k == 3)  btn_in[0] = 1'b1;
         if (k == 10) btn_in[0] = 1'b0;
         if (k == 18) btn_in[0] = 1'b1;
         check("lock_level", level_out,
               {1'b0, (k >= 6), ((k >= 9 && k < 16) || k >= 24)});
         check("lock_pulse", pulse_out,
               (k == 7) ? 3'b010 : ((k == 25) ? 3'b001 : 3'b000));
         check("lock_busy", {2'b00, busy},
               {2'b00, ((k >= 7 && k <= 14) || k >= 25)});
      end

      // Reset asserted in the pulse cycle while busy
      rst = 1'b0;
      #1;
      check("rst_abort_pulse", pulse_out, 3'b000);
      check("rst_abort_busy", {2'b00, busy}, 3'b000);
      check("rst_abort_level", level_out, 3'b000);
      #2;
      rst = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 10) btn_in = 3'b000;
         check("rerel_level", level_out, (k >= 6 && k < 16) ? 3'b011 : 3'b000);
         check("rerel_pulse", pulse_out, (k == 7) ? 3'b001 : 3'b000);
         check("rerel_busy", {2'b00, busy}, {2'b00, (k >= 7 && k <= 14)});
      end

      // Long hold on bit 0
      btn_in = 3'b001;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 60) btn_in = 3'b000;
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
         exp_pulse = (k == 7 || k == 27 || k == 37 || k == 47 || k == 57) ? 3'b001 : 3'b000;
         exp_busy  = (k >= 7 && k <= 14) || (k >= 27 && k <= 64 && ((k - 27) % 10) <= 7);
`else
         exp_pulse = (k == 7) ? 3'b001 : 3'b000;
         exp_busy  = (k >= 7 && k <= 14);
`endif
         check("longhold_level", level_out, (k >= 6 && k < 66) ? 3'b001 : 3'b000);
         check("longhold_pulse", pulse_out, exp_pulse);
         check("longhold_busy", {2'b00, busy}, {2'b00, exp_busy});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_pulse_conditioner.md
Name: button_pulse_conditioner

Overview:
- Parametrised N-channel push-button front end for the game controller.
- Per channel: 2-flop synchroniser, stable-time debouncer and rising-edge detector.
- A shared lockout arbiter emits at most one single-cycle, one-hot move pulse per lockout window.
- Sits between the board buttons and the game FSM. Replaces fixed three-button handling with any channel count and programmable timing.

Parameters:
- NUM_CH, 3, number of button channels (>=1); bit 0 has highest priority.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles before the debounced level changes (>=1).
- LOCKOUT_CYCLES, 15, cycles after any pulse during which new requests are dropped (>=0; 0 means no lockout).
- REPEAT_DELAY, 1000, hold cycles before the first auto-repeat (only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 250, cycles between auto-repeats (only with AUTOREPEAT_EN); must be > LOCKOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_in  in  NUM_CH  raw asynchronous button levels, active-high.
- level_out  out  NUM_CH  debounced button levels.
- pulse_out  out  NUM_CH  one-hot, single-cycle move pulse (registered).
- busy  out  1  high while the lockout counter is non-zero.

Behaviour:
- One clock domain, clk. rst is asynchronous and active-low.
- Reset clears all synchroniser flops, debounce counters, level_out, pulse_out, the lockout counter, busy and repeat counters.
- Reset mid-operation aborts any lockout or hold immediately. No pulse is generated on release of reset, even if a button is held; a held button must pass debounce again.
- Synchroniser: 2 flops per channel. btn_in is never used unsynchronised.
- Debounce, per channel: counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synced input == level_out: counter resets to 0.
  - Otherwise: counter increments. When it would reach DEBOUNCE_CYCLES, level_out toggles and the counter clears.
  - Latency from a clean btn_in edge to level_out: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes level_out.
- Request: req[i] = level_out[i] & ~level_out_d[i], a one-cycle rising edge. Releases never generate requests.
- Arbiter, evaluated each cycle:
  - If lockout counter == 0 and req != 0: next pulse_out = lowest-index set bit of req, and the lockout counter loads LOCKOUT_CYCLES.
  - Otherwise pulse_out = 0.
  - Requests that are not granted are dropped, never queued. This covers simultaneous losers and any request arriving while busy.
- Timing:
  - level_out[i] rises at cycle t -> pulse_out[i] high only in cycle t+1.
  - busy is high in cycles t+1 .. t+LOCKOUT_CYCLES.
  - A request seen in cycle t+LOCKOUT_CYCLES+1 or later is grantable.
- Lockout counter: decrements by 1 per cycle while non-zero and saturates at 0. busy = (counter != 0).
- Invariants:
  - $onehot0(pulse_out) at all times.
  - pulse_out is never high in two consecutive cycles when LOCKOUT_CYCLES >= 1.

Optional Feature:
- Macro: BUTTON_PULSE_AUTOREPEAT_EN.
- Defined:
  - Per-channel hold counter runs while level_out[i] = 1.
  - On reaching REPEAT_DELAY cycles after the rising edge, a one-cycle repeat request is raised; after that, one is raised every REPEAT_PERIOD cycles.
  - Repeat requests are OR'd into req and pass through the same priority and lockout rules; blocked repeats are dropped.
  - Counter clears when level_out[i] falls.
- Undefined: no hold counters exist. A held button yields exactly one pulse. REPEAT_* parameters are ignored.

Test Plan (NUM_CH=3, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8 unless stated):
- Reset hold: btn_in=3'b111 during and after reset release -> level_out reaches 3'b111 after 6 cycles, pulse_out on bit 0 only, then nothing more while held.
- Single press: btn_in[1] rises cleanly at cycle 10 -> level_out[1]=1 at cycle 16, pulse_out=3'b010 in cycle 17 only, busy high cycles 17..24.
- Bounce: btn_in[2] toggles 1,0,1,0 every cycle, then stays 1 -> no level change during the bounce; a single pulse 3'b100 occurs 2+4+1 cycles after the final stable edge.
- Simultaneous: bits 0 and 2 rise on the same cycle -> pulse_out=3'b001 only. Bit 2 is dropped, and pulse_out stays 0 after the lockout.
- Lockout drop and reset: bit 1 pulse, then bit 0 edge 3 cycles later -> no pulse. A third edge after busy falls -> pulse. Asserting rst while busy -> busy=0 and pulse_out=0 immediately.
- Autorepeat (macro on, REPEAT_DELAY=20, REPEAT_PERIOD=10): hold bit 0 for 60 cycles after level_out rises -> pulses at +1, +21, +31, +41, +51; none after release.
